// File: rtl/mem_pkg.sv
// Shared definitions for the LSU data port: op codes, FSM states and lane masks.
package mem_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd12;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_e;

  localparam logic [31:0] LANE_ALL  = 32'hFFFF_FFFF;
  localparam logic [31:0] LANE_BYTE = 32'h0000_00FF;
  localparam logic [31:0] LANE_HALF = 32'h0000_FFFF;

  // Code 7 and 13..15 are holes in the op map.
  function automatic logic op_known(input logic [3:0] op);
    return (op != 4'd7) && (op <= 4'd12);
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Big-endian lane extraction for loads and read-modify-write word build for stores.
module lsu_lane_merge
  import mem_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_k,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [4:0]  w_sk;
  logic [4:0]  w_sr;
  logic [4:0]  w_hs;
  logic [31:0] w_bsh;
  logic [31:0] w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane k sits 8*(3-k) bits above the LSB; 3-k on two bits is ~k.
  assign w_sk   = {i_k, 3'b000};
  assign w_sr   = {~i_k, 3'b000};
  assign w_hs   = i_k[1] ? 5'd0 : 5'd16;
  assign w_bsh  = i_word >> w_sr;
  assign w_hsh  = i_word >> w_hs;
  assign w_byte = w_bsh[7:0];
  assign w_half = w_hsh[15:0];

  always_comb begin
    o_load  = '0;
    o_store = i_word;
    case (i_op)
      OP_LB:  o_load = {{24{w_byte[7]}}, w_byte};
      OP_LBU: o_load = {24'b0, w_byte};
      OP_LH:  o_load = {{16{w_half[15]}}, w_half};
      OP_LHU: o_load = {16'b0, w_half};
      OP_LW:  o_load = i_word;
      OP_LWL: o_load = (i_word << w_sk) | (i_wdata & ~(LANE_ALL << w_sk));
      OP_LWR: o_load = (i_word >> w_sr) | (i_wdata & ~(LANE_ALL >> w_sr));
      OP_SB:  o_store = (i_word & ~(LANE_BYTE << w_sr)) | ({24'b0, i_wdata[7:0]} << w_sr);
      OP_SH:  o_store = (i_word & ~(LANE_HALF << w_hs)) | ({16'b0, i_wdata[15:0]} << w_hs);
      OP_SW:  o_store = i_wdata;
      OP_SWL: o_store = (i_word & ~(LANE_ALL >> w_sk)) | (i_wdata >> w_sk);
      OP_SWR: o_store = (i_wdata << w_sr) | (i_word & ~(LANE_ALL << w_sr));
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// LSU data-port initiator: every access is an aligned word read, stores follow with
// a merged full-word write, and the result returns as a one-cycle response pulse.
module lsu_mem_port
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = 132,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_align_ok;
  logic              w_in_range;
  logic              w_legal;
  logic [ADDR_W:0]   w_end;
  logic [31:0]       w_word;
  logic [31:0]       w_load;
  logic [31:0]       w_store;

  assign w_accept = req_valid && (r_state == IDLE);

  // Last byte of the aligned word, one bit wider so high addresses cannot wrap.
  assign w_end      = {1'b0, req_addr[ADDR_W-1:2], 2'b11};
  assign w_in_range = w_end < (ADDR_W+1)'(MEM_BYTES);

  always_comb begin
    w_align_ok = 1'b1;
    case (req_op)
      OP_LW, OP_SW:         w_align_ok = (req_addr[1:0] == 2'b00);
      OP_LH, OP_LHU, OP_SH: w_align_ok = !req_addr[0];
      default: ;
    endcase
  end

  assign w_legal = op_known(req_op) && w_align_ok && w_in_range;

  // READ merges straight from the memory bus; WRITE uses the word captured in READ.
  assign w_word = (r_state == READ) ? mem_dout : r_word;

  lsu_lane_merge u_merge (
    .i_op    (r_op),
    .i_k     (r_addr[1:0]),
    .i_word  (w_word),
    .i_wdata (r_wdata),
    .o_load  (w_load),
    .o_store (w_store)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_accept) begin
          r_op    <= req_op;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_err   <= !w_legal;
          r_rdata <= '0;
        end
        READ: begin
          r_word <= mem_dout;
          if (!r_op[3]) r_rdata <= w_load;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_legal ? READ : RESP;
      READ:    w_next = r_op[3] ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Write enable is a pure state decode so an async reset kills it immediately.
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_err   = (r_state == RESP) && r_err;
  assign resp_rdata = (r_state == RESP) ? r_rdata : '0;
  assign mem_wr_en  = (r_state == WRITE);
  assign mem_din    = (r_state == WRITE) ? w_store : '0;
  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port against a 33-word falling-edge-write memory model.
module tb_lsu_mem_port;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_wr_en;

  always #5 clk = ~clk;

  lsu_mem_port #(.MEM_BYTES(132), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  logic [31:0] mem [0:32];
  logic        tb_we;
  logic [5:0]  tb_idx;
  logic [31:0] tb_val;

  always_comb mem_dout = (mem_addr[31:2] < 30'd33) ? mem[mem_addr[7:2]] : 32'h0;

  always @(negedge clk) begin
    if (mem_wr_en && (mem_addr[31:2] < 30'd33)) mem[mem_addr[7:2]] <= mem_din;
    else if (tb_we) mem[tb_idx] <= tb_val;
  end

  int total = 0;
  int bad = 0;

  int          o_rcyc, o_wrcnt, o_wrcyc;
  logic [31:0] o_rdata, o_din, o_a1, o_a2;
  logic        o_err, o_rdy1, o_rdy_end;

  task automatic poke(input logic [5:0] i, input logic [31:0] v);
    tb_we = 1'b1; tb_idx = i; tb_val = v;
    @(negedge clk); #1 tb_we = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issue one request and record what happens over cycles 1..4 after the accept edge.
  // While busy, a decoy SW keeps req_valid high; it must not be taken.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    o_rcyc = 0; o_wrcnt = 0; o_wrcyc = 0; o_rdata = '0; o_err = 1'b0;
    o_din = '0; o_a1 = '0; o_a2 = '0; o_rdy1 = 1'b1;
    @(posedge clk); #1;
    req_op = OP_SW; req_addr = 32'h80; req_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      if (c == 1) begin o_a1 = mem_addr; o_rdy1 = req_ready; end
      if (c == 2) o_a2 = mem_addr;
      if (mem_wr_en) begin o_wrcnt++; o_wrcyc = c; o_din = mem_din; end
      if (resp_valid && o_rcyc == 0) begin
        o_rcyc = c; o_rdata = resp_rdata; o_err = resp_err; req_valid = 1'b0;
      end
      if (c < 4) begin @(posedge clk); #1; end
    end
    req_valid = 1'b0;
    o_rdy_end = req_ready;
  endtask

  task automatic test_reset();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", mem_wr_en); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_din !== 32'h0) begin bad++; $display("FAIL rst_mem_din got=%h exp=0", mem_din); end
  endtask

  task automatic test_loads();
    logic [3:0]  ops [12] = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_LH,
                              OP_LWL, OP_LWR, OP_LWL, OP_LWR};
    logic [31:0] adr [12] = '{32'h80, 32'h80, 32'h81, 32'h80, 32'h82, 32'h83, 32'h82, 32'h82,
                              32'h83, 32'h80, 32'h81, 32'h82};
    logic [31:0] exp [12] = '{32'hF11F3DD3, 32'hFFFFFFF1, 32'h0000001F, 32'hFFFFF11F,
                              32'h00003DD3, 32'hFFFFFFD3, 32'h0000003D, 32'h00003DD3,
                              32'hD3223344, 32'h112233F1, 32'h1F3DD344, 32'h11F11F3D};
    for (int i = 0; i < 12; i++) begin
      run(ops[i], adr[i], 32'h11223344);
      total++; if (o_rdata !== exp[i]) begin bad++; $display("FAIL load%0d_rdata got=%h exp=%h", i, o_rdata, exp[i]); end
      total++; if (o_rcyc != 2) begin bad++; $display("FAIL load%0d_latency got=%0d exp=2", i, o_rcyc); end
      total++; if (o_err !== 1'b0) begin bad++; $display("FAIL load%0d_err got=%b exp=0", i, o_err); end
      total++; if (o_wrcnt != 0) begin bad++; $display("FAIL load%0d_writes got=%0d exp=0", i, o_wrcnt); end
      total++; if (o_a1 !== 32'h80) begin bad++; $display("FAIL load%0d_addr got=%h exp=80", i, o_a1); end
      total++; if (o_rdy1 !== 1'b0) begin bad++; $display("FAIL load%0d_busy_ready got=%b exp=0", i, o_rdy1); end
    end
    // Top word of memory: aligned 0x7C+3 = 0x7F is still inside.
    run(OP_LW, 32'h7C, 32'h0);
    total++; if (o_rdata !== 32'h01020304 || o_err !== 1'b0) begin bad++; $display("FAIL lw_top got=%h err=%b exp=01020304 err=0", o_rdata, o_err); end
    run(OP_LWL, 32'h7F, 32'h0);
    total++; if (o_rdata !== 32'h04000000 || o_err !== 1'b0) begin bad++; $display("FAIL lwl_top got=%h err=%b exp=04000000 err=0", o_rdata, o_err); end
  endtask

  task automatic test_stores();
    logic [3:0]  ops [8] = '{OP_SB, OP_SB, OP_SH, OP_SH, OP_SW, OP_SWL, OP_SWL, OP_SWR};
    logic [31:0] adr [8] = '{32'h82, 32'h80, 32'h82, 32'h80, 32'h80, 32'h81, 32'h83, 32'h82};
    logic [31:0] wd  [8] = '{32'h000000AA, 32'h00000077, 32'h00001234, 32'h0000BEEF,
                             32'h12345678, 32'hA1B2C3D4, 32'hA1B2C3D4, 32'hA1B2C3D4};
    logic [31:0] exp [8] = '{32'hF11FAAD3, 32'h771F3DD3, 32'hF11F1234, 32'hBEEF3DD3,
                             32'h12345678, 32'hF1A1B2C3, 32'hF11F3DA1, 32'hB2C3D4D3};
    for (int i = 0; i < 8; i++) begin
      run(ops[i], adr[i], wd[i]);
      total++; if (o_din !== exp[i]) begin bad++; $display("FAIL store%0d_din got=%h exp=%h", i, o_din, exp[i]); end
      total++; if (o_wrcnt != 1 || o_wrcyc != 2) begin bad++; $display("FAIL store%0d_wr got=%0d@%0d exp=1@2", i, o_wrcnt, o_wrcyc); end
      total++; if (o_rcyc != 3) begin bad++; $display("FAIL store%0d_latency got=%0d exp=3", i, o_rcyc); end
      total++; if (o_a1 !== 32'h80 || o_a2 !== 32'h80) begin bad++; $display("FAIL store%0d_addr got=%h,%h exp=80,80", i, o_a1, o_a2); end
      total++; if (o_err !== 1'b0 || o_rdata !== 32'h0) begin bad++; $display("FAIL store%0d_resp got=%h err=%b exp=0 err=0", i, o_rdata, o_err); end
      total++; if (mem[32] !== exp[i]) begin bad++; $display("FAIL store%0d_mem got=%h exp=%h", i, mem[32], exp[i]); end
      total++; if (o_rdy_end !== 1'b1) begin bad++; $display("FAIL store%0d_idle got=%b exp=1", i, o_rdy_end); end
      poke(6'd32, 32'hF11F3DD3);
    end
  endtask

  task automatic test_back_to_back();
    run(OP_SB, 32'h82, 32'h000000AA);
    run(OP_LW, 32'h80, 32'h0);
    total++; if (o_rdata !== 32'hF11FAAD3) begin bad++; $display("FAIL b2b_readback got=%h exp=F11FAAD3", o_rdata); end
    poke(6'd32, 32'hF11F3DD3);
  endtask

  task automatic test_errors();
    logic [3:0]  ops [9] = '{OP_LW, OP_SH, OP_LH, OP_LW, OP_SB, OP_LB, 4'd7, 4'd13, 4'd15};
    logic [31:0] adr [9] = '{32'h82, 32'h81, 32'h83, 32'h84, 32'h84, 32'hFFFFFFFC,
                             32'h80, 32'h80, 32'h80};
    for (int i = 0; i < 9; i++) begin
      run(ops[i], adr[i], 32'h5555_5555);
      total++; if (o_err !== 1'b1) begin bad++; $display("FAIL err%0d_flag got=%b exp=1", i, o_err); end
      total++; if (o_rcyc != 1) begin bad++; $display("FAIL err%0d_latency got=%0d exp=1", i, o_rcyc); end
      total++; if (o_wrcnt != 0) begin bad++; $display("FAIL err%0d_writes got=%0d exp=0", i, o_wrcnt); end
      total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL err%0d_rdata got=%h exp=0", i, o_rdata); end
    end
    total++; if (mem[32] !== 32'hF11F3DD3) begin bad++; $display("FAIL err_mem got=%h exp=F11F3DD3", mem[32]); end
  endtask

  task automatic test_reset_in_write();
    req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h80; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (mem_wr_en !== 1'b1) begin bad++; $display("FAIL rw_write_cycle got=%b exp=1", mem_wr_en); end
    rst_n = 1'b0; #1;
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL rw_wr_drop got=%b exp=0", mem_wr_en); end
    #6;
    total++; if (mem[32] !== 32'hF11F3DD3) begin bad++; $display("FAIL rw_mem got=%h exp=F11F3DD3", mem[32]); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    run(OP_LW, 32'h80, 32'h0);
    total++; if (o_rdata !== 32'hF11F3DD3) begin bad++; $display("FAIL rw_after got=%h exp=F11F3DD3", o_rdata); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    tb_we = 1'b0; tb_idx = '0; tb_val = '0;
    #2;
    test_reset();
    poke(6'd32, 32'hF11F3DD3);
    poke(6'd31, 32'h01020304);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_loads();
    test_stores();
    test_back_to_back();
    test_errors();
    test_reset_in_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator for the data port of the unified byte-addressed, big-endian instruction/data memory.
- The memory writes only full 32-bit words, on the falling edge of clk, and reads combinationally.
- This block turns the MEM stage's byte, halfword, word and unaligned (LWL/LWR/SWL/SWR) requests into aligned word reads plus read-modify-write word writes.
- It returns load data, already merged into rt, to the pipeline through a valid/ready handshake.

Parameters:
MEM_BYTES, 132, size of the memory in bytes; an access whose aligned word does not fit inside it is rejected.
ADDR_W, 32, address width.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  the pipeline presents a request.
req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready at a rising edge.
req_op  input  4  operation code from mem_pkg.
req_addr  input  ADDR_W  byte address; the effective address is already computed.
req_wdata  input  32  rt value used by stores and as the merge source for LWL/LWR.
resp_valid  output  1  one-cycle pulse in RESP.
resp_rdata  output  32  load result, valid while resp_valid is high; 0 for stores.
resp_err  output  1  valid while resp_valid is high; misaligned or out-of-range request.
mem_addr  output  ADDR_W  word-aligned address to memory, {addr[31:2],2'b00}.
mem_wr_en  output  1  memory write enable.
mem_din  output  32  merged write word.
mem_dout  input  32  combinational read word from memory.

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_wr_en=0; mem_addr=0; mem_din=0.
- Reset asserted in any state immediately returns the block to IDLE.
- mem_wr_en is decoded from the state, so a reset asserted during WRITE before the falling edge suppresses the write.
- State machine:
  - IDLE: on accept, register op, addr and wdata, then check legality.
  - Illegal request: go to RESP with err=1. No memory access; mem_wr_en is never raised.
  - Legal request: go to READ.
  - READ: drive mem_addr and register mem_dout at the rising edge. A load computes its result and goes to RESP; a store goes to WRITE.
  - WRITE: mem_wr_en=1 for exactly one cycle, mem_addr held, mem_din = merged word. Then go to RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE.
- There is no back-pressure on resp; the consumer must accept the pulse.
- Latency, counted from the accept edge (cycle 0):
  - loads: resp_valid in cycle 2;
  - stores: write in cycle 2, resp_valid in cycle 3;
  - errors: resp_valid in cycle 1.
- Legality:
  - LW/SW require addr[1:0]=0.
  - LH/LHU/SH require addr[0]=0.
  - All ops require aligned_addr+3 < MEM_BYTES.
  - LWL/LWR/SWL/SWR are always alignment-legal.
- Big-endian lanes: byte offset k=addr[1:0]; lane k is bits [31-8k -: 8]; W = registered memory word.
- Loads:
  - LB/LBU: lane k, sign- or zero-extended.
  - LH/LHU: the halfword at k=0 is W[31:16], at k=2 is W[15:0].
  - LW: W.
  - LWL: (W << 8k) | (rt & ((1<<8k)-1)).
  - LWR: (W >> 8(3-k)) | (rt & ~(32'hFFFFFFFF >> 8(3-k))).
- Stores (merged word written back):
  - SB: replace lane k with wdata[7:0].
  - SH: replace the halfword with wdata[15:0].
  - SW: wdata.
  - SWL: (W & ~(32'hFFFFFFFF >> 8k)) | (wdata >> 8k).
  - SWR: (wdata << 8(3-k)) | (W & ~(32'hFFFFFFFF << 8(3-k))).
- All ops, including SW, take the READ cycle, so timing is uniform.
- req_valid seen while not in IDLE is ignored; the requester holds it.
- Op codes that are not in mem_pkg are treated as illegal: resp_err=1.

Decomposition:
- mem_pkg holds:
  - the op code constants: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=8, SH=9, SW=10, SWL=11, SWR=12 (bit 3 = store);
  - the state encoding: IDLE, READ, WRITE, RESP;
  - the lane-mask constants.
- One combinational sub-module, lsu_lane_merge, takes (op, k, W, wdata) and produces load_result and store_word. The FSM and handshake stay in lsu_mem_port.

Test Plan:
- Word 0x80 preloaded with 0xF11F3DD3; LW 0x80 -> resp_rdata=0xF11F3DD3 in cycle 2, resp_err=0, mem_wr_en never high.
- LB 0x80 -> 0xFFFFFFF1; LBU 0x81 -> 0x0000001F; LH 0x80 -> 0xFFFFF11F; LHU 0x82 -> 0x00003DD3.
- SB 0x82 wdata=0x000000AA -> mem_addr=0x80 in cycles 1-2, mem_wr_en only in cycle 2, mem_din=0xF11FAAD3; a following LW 0x80 returns 0xF11FAAD3.
- Word 0x80 = 0xF11F3DD3, rt=0x11223344: LWL 0x83 -> 0xD3223344; LWR 0x80 -> 0x112233F1. SWR 0x82 rt=0xA1B2C3D4 -> mem_din=0xB2C3D4D3.
- LW 0x82 and SH 0x81 -> resp_err=1 in cycle 1, no write. LW 0x84 with MEM_BYTES=132 -> resp_err=1.
- SW 0x80 with rst_n pulled low during WRITE before the falling clk edge -> mem_wr_en drops at once and memory is unchanged. After release: IDLE, req_ready=1, all outputs at reset values.
